// File: rtl/button_debouncer_pkg.sv
// Shared types and default constants for the push-button debouncer.
package button_pkg;

    // Debounce FSM states; btn_level is high in PRESSED and RELEASE_WAIT.
    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    // 10 ms and 1 s at a 100 MHz clock.
    localparam int unsigned DEFAULT_STABLE_CYCLES = 1_000_000;
    localparam int unsigned DEFAULT_LONG_CYCLES   = 100_000_000;

    // True in the states where the debounced button reads as pressed.
    function automatic logic is_held(input btn_state_t s);
        return (s == PRESSED) || (s == RELEASE_WAIT);
    endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// Button-side signal bundle: raw pin in, debounced level and strobes out.
// Strobe semantics: press_pulse, release_pulse and long_pulse are
// single-cycle, active-high event strobes with no back-pressure; the
// consumer must sample them every clock. btn_level is a steady level.
interface button_debouncer_if;
    logic btn_in;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;

    // Side that owns the pin and consumes the debounced events.
    modport master (
        output btn_in,
        input  btn_level,
        input  press_pulse,
        input  release_pulse,
        input  long_pulse
    );

    // Debouncer side.
    modport slave (
        input  btn_in,
        output btn_level,
        output press_pulse,
        output release_pulse,
        output long_pulse
    );
endinterface

// File: rtl/button_debouncer_sync.sv
// Two-flop synchronizer for the raw asynchronous button pin.
module sync_2ff (
    input  logic clk,
    input  logic n_reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; the first may go metastable, the second resolves it.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer: 2-flop synchronizer, 4-state qualification FSM,
// registered level and press/release strobes.
// Optional long-press strobe is enabled by defining BUTTON_DEBOUNCER_LONG_PRESS_EN;
// without it long_pulse is tied low and no long counter exists.
module button_debouncer
    import button_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int unsigned LONG_CYCLES   = DEFAULT_LONG_CYCLES
) (
    input  logic                 clk,
    input  logic                 n_reset,
    button_debouncer_if.slave    bus,
    output btn_state_t           state_dbg
);

    // One width for both counters, sized so the long count fits without wrap.
    localparam int CNT_W = $clog2(LONG_CYCLES + 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    logic             btn_sync;
    btn_state_t       state;
    btn_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             press_set;
    logic             release_set;
    logic             level_q;
    logic             press_q;
    logic             release_q;

    sync_2ff u_sync (
        .clk     (clk),
        .n_reset (n_reset),
        .d       (bus.btn_in),
        .q       (btn_sync)
    );

    // Saturating increment: the stability counter never wraps.
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

    // Next-state logic; a candidate edge must hold for STABLE_CYCLES samples.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        press_set   = 1'b0;
        release_set = 1'b0;
        case (state)
            RELEASED: begin
                if (btn_sync) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_sync) begin
                    state_nxt = RELEASED;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = PRESSED;
                    press_set = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            PRESSED: begin
                if (!btn_sync) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btn_sync) begin
                    state_nxt = PRESSED;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt   = RELEASED;
                    release_set = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt = RELEASED;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and registered outputs; reset discards any press in flight.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state     <= RELEASED;
            cnt       <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            level_q   <= is_held(state_nxt);
            press_q   <= press_set;
            release_q <= release_set;
        end
    end

    assign bus.btn_level     = level_q;
    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;
    assign state_dbg         = state;

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_SAT  = CNT_W'(LONG_CYCLES);

    logic [CNT_W-1:0] long_cnt;
    logic             long_q;

    // Long counter runs while held; it passes LONG_LAST once per press and
    // then parks at LONG_SAT, so the strobe cannot repeat.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            long_cnt <= '0;
            long_q   <= 1'b0;
        end else begin
            long_q <= is_held(state) && (long_cnt == LONG_LAST);
            if (press_set || release_set) begin
                long_cnt <= '0;
            end else if (is_held(state) && (long_cnt != LONG_SAT)) begin
                long_cnt <= long_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.long_pulse = long_q;
`else
    assign bus.long_pulse = 1'b0;
`endif

endmodule
